// File: rtl/mips_fetch_stage.sv
// MIPS instruction fetch stage: single-outstanding imem requester
// feeding the IF/ID register through a one-entry skid buffer.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  NOP_OPFIELD = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  opfield,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        sk_v_q, sk_v_d;
  logic [31:0] sk_instr_q, sk_instr_d;
  logic [31:0] sk_pc4_q, sk_pc4_d;
  logic        v_q, v_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] cnt_q, cnt_d;
  logic        deliver;

  assign imem_req    = (state_q == IDLE) & ~sk_v_q & ~branch_taken;
  assign imem_addr   = {pc_q[31:2], 2'b00};
  assign if_id_valid = v_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign opfield     = v_q ? instr_q[31:26] : NOP_OPFIELD;
  assign fetch_count = cnt_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    sk_v_d     = sk_v_q;
    sk_instr_d = sk_instr_q;
    sk_pc4_d   = sk_pc4_q;
    v_d        = v_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    cnt_d      = cnt_q;
    deliver    = 1'b0;
    if (branch_taken) begin
      // Flush everything; an in-flight response must still be absorbed
      pc_d   = {branch_target[31:2], 2'b00};
      v_d    = 1'b0;
      sk_v_d = 1'b0;
      unique case (state_q)
        IDLE:       state_d = IDLE;
        WAIT, DROP: state_d = imem_rvalid ? IDLE : DROP;
        default:    state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (imem_req && imem_gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            deliver = 1'b1;
            state_d = IDLE;
          end
        end
        DROP: begin
          if (imem_rvalid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (deliver) begin
        if (!v_q || !stall) begin
          v_d     = 1'b1;
          instr_d = imem_rdata;
          pc4_d   = req_pc_q + 32'd4;
          cnt_d   = cnt_q + 32'd1;
        end else begin
          sk_v_d     = 1'b1;
          sk_instr_d = imem_rdata;
          sk_pc4_d   = req_pc_q + 32'd4;
        end
      end else if (!stall) begin
        if (sk_v_q) begin
          v_d     = 1'b1;
          instr_d = sk_instr_q;
          pc4_d   = sk_pc4_q;
          sk_v_d  = 1'b0;
          cnt_d   = cnt_q + 32'd1;
        end else begin
          v_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'd0;
      sk_v_q     <= 1'b0;
      sk_instr_q <= 32'd0;
      sk_pc4_q   <= 32'd0;
      v_q        <= 1'b0;
      instr_q    <= 32'd0;
      pc4_q      <= 32'd0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      sk_v_q     <= sk_v_d;
      sk_instr_q <= sk_instr_d;
      sk_pc4_q   <= sk_pc4_d;
      v_q        <= v_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: latency-programmable imem model and
// an in-order scoreboard of granted fetches.
module tb_mips_fetch_stage;

  localparam logic [5:0] NOP = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  opfield;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  mips_fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .opfield      (opfield),
    .fetch_count  (fetch_count)
  );

  logic [63:0] exp_q[$];
  logic [31:0] exp_pc = 32'd0;
  logic [31:0] mem_addr = 32'd0;
  int          mem_cnt = 0;
  bit          mem_busy = 1'b0;
  int          lat = 1;
  bit          gnt_rand = 1'b0;
  bit          br_on_rv = 1'b0;
  bit          rst_next = 1'b0;
  bit          chk_reset = 1'b0;
  bit          chk_cnt = 1'b0;
  bit          granted_last = 1'b0;
  int          loads_ref = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h8) return 32'h8C01_0000;
    return (a * 32'h9E37_79B1) ^ 32'h1357_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit s, input bit br, input logic [31:0] tgt);
    logic [63:0] e;
    @(negedge clk);
    rst_n         = rst_next;
    stall         = s;
    imem_rvalid   = mem_busy && (mem_cnt == 0);
    imem_rdata    = imem_rvalid ? memf(mem_addr) : 32'hDEAD_BEEF;
    imem_gnt      = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    branch_taken  = br | (br_on_rv & imem_rvalid);
    branch_target = tgt;
    #1;
    granted_last = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      exp_pc    = 32'd0;
      loads_ref = 0;
      mem_busy  = 1'b0;
    end else begin
      if (chk_reset) begin
        chk_reset = 1'b0;
        check("rst_req", imem_req, 1'b1);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", if_id_valid, 1'b0);
        check("rst_instr", if_id_instr, 32'd0);
        check("rst_pc4", if_id_pc4, 32'd0);
        check("rst_count", fetch_count, 32'd0);
      end
      if (chk_cnt) begin
        chk_cnt = 1'b0;
        check("fetch_count", fetch_count, 32'(loads_ref) + 32'(if_id_valid));
      end
      if (!if_id_valid) check("opfield_nop", opfield, NOP);
      if (branch_taken) begin
        if (if_id_valid) loads_ref++;
        exp_q.delete();
        exp_pc = {tgt[31:2], 2'b00};
      end else if (if_id_valid && !stall) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("ifid_instr", if_id_instr, e[63:32]);
          check("ifid_pc4", if_id_pc4, e[31:0]);
          check("opfield", opfield, e[63:58]);
          loads_ref++;
        end
      end
      if (imem_req && imem_gnt) begin
        check("imem_addr", imem_addr, exp_pc);
        exp_q.push_back({memf(exp_pc), exp_pc + 32'd4});
        exp_pc = exp_pc + 32'd4;
        granted_last = 1'b1;
      end
      if (imem_rvalid) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (imem_req && imem_gnt) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = lat - 1;
      end
    end
  endtask

  task automatic do_reset();
    rst_next = 1'b0;
    repeat (2) cycle(0, 0, 32'd0);
    rst_next  = 1'b1;
    chk_reset = 1'b1;
    cycle(0, 0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    do_reset();

    // Streaming fetch with single-cycle memory
    repeat (20) cycle(0, 0, 32'd0);
    chk_cnt = 1'b1;
    cycle(0, 0, 32'd0);

    // Hold downstream until the skid buffer fills
    repeat (5) cycle(1, 0, 32'd0);
    cycle(1, 0, 32'd0);
    check("stall_req", imem_req, 1'b0);
    check("stall_valid", if_id_valid, 1'b1);
    repeat (10) cycle(0, 0, 32'd0);
    chk_cnt = 1'b1;
    cycle(0, 0, 32'd0);

    // Redirect while a 3-cycle request is in flight
    lat = 3;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 32'd0);
      if (granted_last) break;
    end
    cycle(0, 1, 32'h0000_0100);
    cycle(0, 0, 32'd0);
    check("drop_req", imem_req, 1'b0);
    check("drop_valid", if_id_valid, 1'b0);
    cycle(0, 0, 32'd0);
    check("drop_req2", imem_req, 1'b0);
    cycle(0, 0, 32'd0);
    check("redir_req", imem_req, 1'b1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    repeat (10) cycle(0, 0, 32'd0);

    // Redirect coinciding with a response under stall, unaligned target
    lat = 2;
    br_on_rv = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 0, 32'h0000_0203);
      if (branch_taken) break;
    end
    check("br_rv_seen", branch_taken, 1'b1);
    br_on_rv = 1'b0;
    cycle(1, 0, 32'd0);
    check("brrv_valid", if_id_valid, 1'b0);
    check("brrv_req", imem_req, 1'b1);
    check("brrv_addr", imem_addr, 32'h0000_0200);
    repeat (10) cycle(0, 0, 32'd0);

    // PC wrap at the top of the address space
    lat = 1;
    cycle(0, 1, 32'hFFFF_FFF8);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 32'd0);
      if (if_id_valid && if_id_instr == memf(32'hFFFF_FFFC)) begin
        check("wrap_pc4", if_id_pc4, 32'd0);
        found = 1'b1;
        break;
      end
    end
    check("wrap_seen", found, 1'b1);
    repeat (6) cycle(0, 0, 32'd0);

    // Mixed random traffic
    gnt_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      lat = $urandom_range(1, 3);
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
            $urandom);
    end
    chk_cnt = 1'b1;
    cycle(0, 0, 32'd0);

    // Reset in the middle of traffic
    lat = 3;
    repeat (3) cycle(0, 0, 32'd0);
    gnt_rand = 1'b0;
    do_reset();
    repeat (30) cycle($urandom_range(0, 3) == 0, 1'b0, 32'd0);
    chk_cnt = 1'b1;
    cycle(0, 0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
